// File: rtl/gecko_pkg.sv
// Shared types for the gecko writeback register file: per-register status,
// the 32-entry status vector, the writeback result and the sweep FSM states.
package gecko_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        VALID   = 2'd0,
        PENDING = 2'd1,
        FULL    = 2'd2
    } gecko_reg_status_t;

    typedef gecko_reg_status_t [NUM_REGS-1:0] gecko_reg_status_arr_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       value;
    } gecko_wb_result_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } gecko_wb_state_t;

endpackage

// File: rtl/gecko_reg_counter.sv
// Saturating up/down count of outstanding writes for one architectural register.
// A simultaneous inc and dec cancel; overflow and underflow pulse err.
module gecko_reg_counter
    import gecko_pkg::*;
#(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output gecko_reg_status_t status,
    output logic              err
);

    localparam logic [COUNTER_WIDTH-1:0] MAX_COUNT = '1;

    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        err     = 1'b0;
        unique case ({inc, dec})
            2'b10: begin
                if (count_q == MAX_COUNT) err = 1'b1;
                else                      count_d = count_q + 1'b1;
            end
            2'b01: begin
                if (count_q == '0) err = 1'b1;
                else               count_d = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (count_q == '0)             status = VALID;
        else if (count_q == MAX_COUNT) status = FULL;
        else                           status = PENDING;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/gecko_writeback_regfile.sv
// 32x32 integer register file with per-register outstanding-write tracking and
// a post-reset clear sweep. Define GECKO_WB_BYPASS_EN for same-cycle writeback forwarding.
module gecko_writeback_regfile
    import gecko_pkg::*;
#(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reserve_valid,
    input  logic [4:0]            reserve_addr,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [4:0]            wb_addr,
    input  logic [31:0]           wb_value,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [31:0]           rs1_value,
    output logic [31:0]           rs2_value,
    output gecko_reg_status_arr_t reg_status,
    output logic                  init_done,
    output logic                  error
);

    gecko_wb_state_t       state_q, state_d;
    logic [4:0]            sweep_q, sweep_d;
    logic                  error_q, error_d;
    gecko_reg_status_arr_t reg_status_q, reg_status_d;
    logic [XLEN-1:0]       regs_q [NUM_REGS];

    gecko_wb_result_t      wb_res;
    logic                  wb_fire;
    logic                  reserve_run;
    logic                  wr_en;
    logic [4:0]            wr_addr;
    logic [XLEN-1:0]       wr_data;
    gecko_reg_status_t     cnt_status [NUM_REGS];
    logic [NUM_REGS-1:0]   cnt_err;

    assign wb_ready    = (state_q == ST_RUN);
    assign init_done   = (state_q == ST_RUN);
    assign error       = error_q;
    assign reg_status  = reg_status_q;
    assign wb_fire     = wb_valid && wb_ready;
    assign wb_res      = '{addr: wb_addr, value: wb_value};
    assign reserve_run = reserve_valid && (state_q == ST_RUN) && (reserve_addr != '0);

    // x0 is hardwired, so it carries no counter and is always VALID.
    assign cnt_status[0] = VALID;
    assign cnt_err[0]    = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        gecko_reg_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc    (reserve_run && (reserve_addr == 5'(i))),
            .dec    (wb_fire && (wb_res.addr == 5'(i))),
            .status (cnt_status[i]),
            .err    (cnt_err[i])
        );
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        wr_en   = 1'b0;
        wr_addr = sweep_q;
        wr_data = '0;
        unique case (state_q)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                sweep_d = sweep_q + 5'd1;
                if (sweep_q == 5'd31) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (wb_fire && (wb_res.addr != '0)) begin
                    wr_en   = 1'b1;
                    wr_addr = wb_res.addr;
                    wr_data = wb_res.value;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        error_d = error_q | (|cnt_err) | (reserve_valid && (state_q == ST_CLEAR));
    end

    // Status follows the counters one cycle late and reads FULL until the sweep completes.
    always_comb begin
        reg_status_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_status_d[i] = (state_d == ST_RUN) ? cnt_status[i] : FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            sweep_q      <= '0;
            error_q      <= 1'b0;
            reg_status_q <= {NUM_REGS{FULL}};
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            error_q      <= error_d;
            reg_status_q <= reg_status_d;
        end
    end

    // NOTE: the storage array has no reset; the CLEAR sweep zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (wr_en) regs_q[wr_addr] <= wr_data;
    end

`ifdef GECKO_WB_BYPASS_EN
    always_comb begin
        rs1_value = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        rs2_value = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
        if (wb_fire && (rs1_addr != '0) && (rs1_addr == wb_res.addr)) rs1_value = wb_res.value;
        if (wb_fire && (rs2_addr != '0) && (rs2_addr == wb_res.addr)) rs2_value = wb_res.value;
    end
`else
    always_comb begin
        rs1_value = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        rs2_value = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
    end
`endif

endmodule

// File: tb/tb_gecko_writeback_regfile.sv
// Directed self-checking bench for gecko_writeback_regfile (COUNTER_WIDTH=2).
// Inputs change 1ns after the rising edge; outputs are sampled in that same window.
module tb_gecko_writeback_regfile;
    import gecko_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  reserve_valid;
    logic [4:0]            reserve_addr;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [4:0]            wb_addr;
    logic [31:0]           wb_value;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic [31:0]           rs1_value;
    logic [31:0]           rs2_value;
    gecko_reg_status_arr_t reg_status;
    logic                  init_done;
    logic                  error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gecko_writeback_regfile #(.COUNTER_WIDTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_value      (wb_value),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
        .reg_status    (reg_status),
        .init_done     (init_done),
        .error         (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reserve_valid = 1'b0;
        reserve_addr  = '0;
        wb_valid      = 1'b0;
        wb_addr       = '0;
        wb_value      = '0;
    endtask

    task automatic do_reserve(input logic [4:0] a);
        reserve_valid = 1'b1;
        reserve_addr  = a;
        tick();
        idle_inputs();
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [31:0] v);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_value = v;
        tick();
        idle_inputs();
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int cyc = 0;
        while (!init_done && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (init_done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s init_timeout: init_done=%b required 1 within 40 cycles", tag, init_done);
        end
    endtask

    task automatic test_reset();
        int bad_status = 0;
        int bad_read   = 0;
        apply_reset();
        n_checks++;
        if (error !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_error: got %b required 0", error);
        end
        for (int c = 1; c <= 32; c++) begin
            n_checks++;
            if (init_done !== 1'b0 || wb_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL clear_ctrl cycle %0d: init_done=%b wb_ready=%b required 0/0", c, init_done, wb_ready);
            end
            for (int r = 0; r < 32; r++) if (reg_status[r] !== FULL) bad_status++;
            tick();
        end
        n_checks++;
        if (bad_status != 0) begin
            n_errors++;
            $display("FAIL clear_status: %0d non-FULL samples required 0", bad_status);
        end
        n_checks++;
        if (init_done !== 1'b1 || wb_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL run_entry cycle 33: init_done=%b wb_ready=%b required 1/1", init_done, wb_ready);
        end
        bad_status = 0;
        for (int r = 0; r < 32; r++) if (reg_status[r] !== VALID) bad_status++;
        n_checks++;
        if (bad_status != 0) begin
            n_errors++;
            $display("FAIL run_status: %0d non-VALID registers required 0", bad_status);
        end
        for (int r = 0; r < 32; r++) begin
            rs1_addr = 5'(r);
            rs2_addr = 5'(31 - r);
            #1;
            if (rs1_value !== 32'h0 || rs2_value !== 32'h0) bad_read++;
        end
        n_checks++;
        if (bad_read != 0) begin
            n_errors++;
            $display("FAIL swept_reads: %0d nonzero reads required 0", bad_read);
        end
    endtask

    task automatic test_reserve_wb();
        do_reserve(5'd5);
        n_checks++;
        if (reg_status[5] !== VALID) begin
            n_errors++;
            $display("FAIL x5_status_lag: got %s required VALID", reg_status[5].name());
        end
        tick();
        n_checks++;
        if (reg_status[5] !== PENDING) begin
            n_errors++;
            $display("FAIL x5_pending: got %s required PENDING", reg_status[5].name());
        end
        do_wb(5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        #1;
        n_checks++;
        if (reg_status[5] !== PENDING || rs1_value !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL x5_after_wb: status=%s value=%h required PENDING/deadbeef", reg_status[5].name(), rs1_value);
        end
        tick();
        n_checks++;
        if (reg_status[5] !== VALID || error !== 1'b0) begin
            n_errors++;
            $display("FAIL x5_valid: status=%s error=%b required VALID/0", reg_status[5].name(), error);
        end
    endtask

    task automatic test_same_cycle();
        do_reserve(5'd9);
        tick();
        reserve_valid = 1'b1;
        reserve_addr  = 5'd9;
        wb_valid      = 1'b1;
        wb_addr       = 5'd9;
        wb_value      = 32'h0000_1234;
        tick();
        idle_inputs();
        tick();
        rs1_addr = 5'd9;
        #1;
        n_checks++;
        if (reg_status[9] !== PENDING || rs1_value !== 32'h0000_1234 || error !== 1'b0) begin
            n_errors++;
            $display("FAIL x9_same_cycle: status=%s value=%h error=%b required PENDING/00001234/0",
                     reg_status[9].name(), rs1_value, error);
        end
        do_wb(5'd9, 32'h0000_5678);
        tick();
        n_checks++;
        if (reg_status[9] !== VALID) begin
            n_errors++;
            $display("FAIL x9_drain: got %s required VALID", reg_status[9].name());
        end
    endtask

    task automatic test_x0_and_underflow();
        wb_valid = 1'b1;
        wb_addr  = 5'd0;
        wb_value = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (wb_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL x0_wb_ready: got %b required 1", wb_ready);
        end
        tick();
        idle_inputs();
        rs1_addr = 5'd0;
        #1;
        n_checks++;
        if (rs1_value !== 32'h0 || error !== 1'b0 || reg_status[0] !== VALID) begin
            n_errors++;
            $display("FAIL x0_write: value=%h error=%b status=%s required 00000000/0/VALID",
                     rs1_value, error, reg_status[0].name());
        end
        do_wb(5'd3, 32'h0000_0055);
        rs1_addr = 5'd3;
        #1;
        n_checks++;
        if (error !== 1'b1 || rs1_value !== 32'h0000_0055) begin
            n_errors++;
            $display("FAIL x3_underflow: error=%b value=%h required 1/00000055", error, rs1_value);
        end
        tick();
        n_checks++;
        if (reg_status[3] !== VALID || error !== 1'b1) begin
            n_errors++;
            $display("FAIL x3_after: status=%s error=%b required VALID/1 (sticky)", reg_status[3].name(), error);
        end
    endtask

    task automatic test_reset_midrun();
        do_reserve(5'd10);
        apply_reset();
        n_checks++;
        if (init_done !== 1'b0 || error !== 1'b0 || reg_status[10] !== FULL) begin
            n_errors++;
            $display("FAIL midrun_reset: init_done=%b error=%b status10=%s required 0/0/FULL",
                     init_done, error, reg_status[10].name());
        end
        wait_init("midrun");
        rs1_addr = 5'd5;
        rs2_addr = 5'd9;
        #1;
        n_checks++;
        if (reg_status[10] !== VALID || rs1_value !== 32'h0 || rs2_value !== 32'h0) begin
            n_errors++;
            $display("FAIL midrun_rezero: status10=%s x5=%h x9=%h required VALID/0/0",
                     reg_status[10].name(), rs1_value, rs2_value);
        end
    endtask

    task automatic test_saturate();
        gecko_reg_status_t exp_seq [3] = '{PENDING, PENDING, FULL};
        for (int k = 0; k < 3; k++) begin
            do_reserve(5'd7);
            tick();
            n_checks++;
            if (reg_status[7] !== exp_seq[k]) begin
                n_errors++;
                $display("FAIL x7_reserve_%0d: got %s required %s", k + 1, reg_status[7].name(), exp_seq[k].name());
            end
        end
        n_checks++;
        if (error !== 1'b0) begin
            n_errors++;
            $display("FAIL x7_pre_overflow_error: got %b required 0", error);
        end
        do_reserve(5'd7);
        tick();
        n_checks++;
        if (error !== 1'b1 || reg_status[7] !== FULL) begin
            n_errors++;
            $display("FAIL x7_overflow: error=%b status=%s required 1/FULL", error, reg_status[7].name());
        end
        do_wb(5'd7, 32'h7);
        tick();
        n_checks++;
        if (reg_status[7] !== PENDING) begin
            n_errors++;
            $display("FAIL x7_count_held: got %s required PENDING (count 2)", reg_status[7].name());
        end
        do_wb(5'd7, 32'h7);
        do_wb(5'd7, 32'h7);
        tick();
        n_checks++;
        if (reg_status[7] !== VALID) begin
            n_errors++;
            $display("FAIL x7_drain: got %s required VALID", reg_status[7].name());
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        do_wb(5'd4, 32'h1111_1111);
        rs2_addr = 5'd4;
        wb_valid = 1'b1;
        wb_addr  = 5'd4;
        wb_value = 32'hA5A5_A5A5;
        #1;
`ifdef GECKO_WB_BYPASS_EN
        exp_same = 32'hA5A5_A5A5;
`else
        exp_same = 32'h1111_1111;
`endif
        n_checks++;
        if (rs2_value !== exp_same) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: got %h required %h", rs2_value, exp_same);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rs2_value !== 32'hA5A5_A5A5) begin
            n_errors++;
            $display("FAIL bypass_next_cycle: got %h required a5a5a5a5", rs2_value);
        end
    endtask

    task automatic test_clear_reserve();
        apply_reset();
        tick();
        tick();
        n_checks++;
        if (error !== 1'b0 || wb_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_pre: error=%b wb_ready=%b required 0/0", error, wb_ready);
        end
        do_reserve(5'd12);
        n_checks++;
        if (error !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_reserve_error: got %b required 1", error);
        end
        wait_init("clear_reserve");
        n_checks++;
        if (reg_status[12] !== VALID) begin
            n_errors++;
            $display("FAIL clear_reserve_ignored: got %s required VALID", reg_status[12].name());
        end
    endtask

    initial begin
        rst      = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        idle_inputs();
        test_reset();
        test_reserve_wb();
        test_same_cycle();
        test_x0_and_underflow();
        test_reset_midrun();
        test_saturate();
        test_bypass();
        test_clear_reserve();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000ns");
        $fatal(1, "watchdog");
    end

endmodule
